fsk_frame_sync: RTL and testbench
=================================

# fsk_frame_sync

Symbol-rate back end of the FSK demodulator. Sits directly downstream of the decimator and consumes its scaled 16-bit signed symbol samples, one per symbol strobe. Slices each sample to a bit with hysteresis, hunts for a 16-bit sync word with a configurable bit-error tolerance, then assembles a fixed-length payload into bytes for the framing/UART stage.

## Interface

Parameters:
- SYNC_WORD, 16'hEB90: sync pattern, MSB received first.
- MAX_ERR, 1: maximum Hamming distance (0..3) accepted as a sync match.
- PAYLOAD_BYTES, 4: bytes per frame after sync (1..255).
- HYST, 16'sd256: slicer threshold magnitude, positive.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset; clears all state.
- x  input  16  signed symbol sample from the decimator.
- x_valid  input  1  one-cycle strobe, x is valid. May be asserted on consecutive cycles.
- bit_out  output  1  current sliced bit, registered.
- byte_out  output  8  last assembled payload byte; held until the next byte.
- byte_valid  output  1  one-cycle pulse, byte_out updated.
- frame_start  output  1  one-cycle pulse, sync accepted.
- frame_done  output  1  one-cycle pulse, last payload byte emitted.
- locked  output  1  high while in DATA.

## Operation

- Slicer, evaluated only on x_valid: x > HYST gives 1, x < -HYST gives 0, otherwise the previous bit is held. Strict comparisons, so x = ±HYST holds. Arithmetic is signed 16-bit, and x = -32768 is a valid 0.
- States:
  - HUNT: each sliced bit shifts into sr[15:0] MSB-first; fill counts shifts, saturating at 16. When fill reaches 16 (counting the current shift) and popcount(next_sr ^ SYNC_WORD) <= MAX_ERR, go to DATA, pulse frame_start, clear bit_cnt and byte_cnt.
  - DATA: each sliced bit shifts into a byte accumulator MSB-first. On the 8th bit, load byte_out, pulse byte_valid and increment byte_cnt. When byte_cnt reaches PAYLOAD_BYTES, pulse frame_done together with the final byte_valid, clear fill and sr, and return to HUNT.
- The payload begins with the bit after the last sync bit. The sync bits are never emitted.
- Sync search is suspended in DATA. A sync pattern inside the payload is treated as data.
- A new sync can be accepted no earlier than 16 symbols after frame_done.
- Reset values:
  - state HUNT; sr, fill, bit_cnt, byte_cnt = 0.
  - bit_out = 0, byte_out = 8'h00.
  - byte_valid, frame_start, frame_done, locked = 0.
- Reset asserted mid-frame aborts the frame immediately. No frame_done is issued and the partial byte is discarded.

## Timing

- All outputs are registered.
- Latency from the x_valid cycle to the bit_out update: 1 cycle.
- frame_start pulses the cycle after the x_valid cycle carrying the 16th sync bit. locked rises on that same cycle.
- byte_valid pulses the cycle after the x_valid cycle carrying the 8th bit of a byte.
- frame_done pulses on the same cycle as the last byte_valid. locked falls on that same cycle.
- Back-to-back x_valid is supported at full clock rate with no lost symbols.
- Cycles without x_valid change nothing except clearing the pulse outputs.

## Configuration

- FSK_AUTO_POLARITY_EN:
  - Defined: HUNT also accepts popcount(next_sr ^ ~SYNC_WORD) <= MAX_ERR. A match on the inverted word sets an internal invert flag for the frame, and every payload bit is complemented before byte assembly. The flag clears on frame_done or reset. If both matches qualify (impossible for MAX_ERR < 8), the true polarity wins.
  - Undefined: only the true SYNC_WORD is matched and no inversion logic exists.

## Test plan

- Reset and idle:
  - Stimulus: assert reset asynchronously between edges with x_valid toggling.
  - Required: all outputs 0 immediately; after release, constant x = 0 gives bit_out = 0 and no pulses.
- Clean frame:
  - Stimulus: send 0xEB90 then 0x12, 0x34, 0x56, 0x78 as x = ±4000, one x_valid every 32 cycles.
  - Required: one frame_start; byte_valid x4 with bytes 12,34,56,78; frame_done coincides with the 78 byte.
- Error tolerance:
  - Stimulus: send sync 0xEB91 (1 error), then sync 0xEB93 (2 errors), each followed by a payload.
  - Required: first is accepted with MAX_ERR = 1; second produces no frame_start.
- Hysteresis:
  - Stimulus: after a 1, send x = 256, then -256, then -257.
  - Required: bit_out = 1, 1, then 0.
- Back-to-back strobes with mid-frame reset:
  - Stimulus: x_valid every cycle; assert reset after 2 payload bytes.
  - Required: exactly 2 byte_valid, no frame_done, locked = 0; the next sync is then accepted normally.
- With FSK_AUTO_POLARITY_EN:
  - Stimulus: send 0x146F followed by inverted payload 0xED.
  - Required: frame_start, then byte_out = 0x12.

Source files
------------

// File: rtl/fsk_frame_sync.sv
// ---------------------------------------------------------------------------
// fsk_frame_sync
//
// Symbol-rate back end of the FSK demodulator. Each strobed 16-bit signed
// symbol sample is sliced to a bit with hysteresis. In HUNT the bits are
// searched for a 16-bit sync word within a Hamming-distance tolerance. In
// DATA a fixed-length payload is packed MSB-first into bytes.
//
// Optional feature macro: FSK_AUTO_POLARITY_EN
//   When defined, the bit-inverted sync word is also accepted. The payload of
//   that frame is then complemented before byte assembly.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset; clears all state
//   x            signed symbol sample, valid when x_valid is high
//   x_valid      one-cycle sample strobe (may be high on consecutive cycles)
//   bit_out      current sliced bit (registered)
//   byte_out     last assembled payload byte, held until the next byte
//   byte_valid   one-cycle pulse, byte_out updated
//   frame_start  one-cycle pulse, sync accepted
//   frame_done   one-cycle pulse, last payload byte emitted
//   locked       high while in DATA
// ---------------------------------------------------------------------------
module fsk_frame_sync #(
    parameter logic [15:0]        SYNC_WORD     = 16'hEB90,
    parameter int                 MAX_ERR       = 1,
    parameter int                 PAYLOAD_BYTES = 4,
    parameter logic signed [15:0] HYST          = 16'sd256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] x,
    input  logic               x_valid,
    output logic               bit_out,
    output logic [7:0]         byte_out,
    output logic               byte_valid,
    output logic               frame_start,
    output logic               frame_done,
    output logic               locked
);

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [4:0]  fill_q, fill_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic        bit_out_q, bit_out_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic        locked_q, locked_d;

    logic        slice_bit_s;
    logic        data_bit_s;
    logic [15:0] sr_shift_s;
    logic [4:0]  fill_inc_s;
    logic [7:0]  acc_shift_s;
    logic [7:0]  byte_inc_s;
    logic        match_true_s;
    logic        sync_hit_s;

`ifdef FSK_AUTO_POLARITY_EN
    logic        invert_q, invert_d;
    logic        match_inv_s;
`endif

    // Number of set bits in a 16-bit word (Hamming weight).
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Slicer, shift-register candidates and sync-match detection.
    always_comb begin
        // Strict compares: samples exactly at +/-HYST hold the previous bit.
        if (x > HYST) begin
            slice_bit_s = 1'b1;
        end else if (x < -HYST) begin
            slice_bit_s = 1'b0;
        end else begin
            slice_bit_s = bit_out_q;
        end
        sr_shift_s   = {sr_q[14:0], slice_bit_s};
        fill_inc_s   = (fill_q == 5'd16) ? 5'd16 : (fill_q + 5'd1);
        byte_inc_s   = byte_cnt_q + 8'd1;
        match_true_s = (popcount16(sr_shift_s ^ SYNC_WORD) <= 5'(MAX_ERR));
`ifdef FSK_AUTO_POLARITY_EN
        match_inv_s  = (popcount16(sr_shift_s ^ ~SYNC_WORD) <= 5'(MAX_ERR));
        sync_hit_s   = (fill_inc_s == 5'd16) && (match_true_s || match_inv_s);
        data_bit_s   = slice_bit_s ^ invert_q;
`else
        sync_hit_s   = (fill_inc_s == 5'd16) && match_true_s;
        data_bit_s   = slice_bit_s;
`endif
        acc_shift_s  = {acc_q[6:0], data_bit_s};
    end

    // Next-state logic: HUNT/DATA sequencing, byte assembly and pulses.
    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        fill_d        = fill_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        acc_d         = acc_q;
        bit_out_d     = bit_out_q;
        byte_out_d    = byte_out_q;
        byte_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
`ifdef FSK_AUTO_POLARITY_EN
        invert_d      = invert_q;
`endif
        if (x_valid) begin
            bit_out_d = slice_bit_s;
            case (state_q)
                ST_HUNT: begin
                    sr_d   = sr_shift_s;
                    fill_d = fill_inc_s;
                    if (sync_hit_s) begin
                        state_d       = ST_DATA;
                        frame_start_d = 1'b1;
                        bit_cnt_d     = 3'd0;
                        byte_cnt_d    = 8'd0;
`ifdef FSK_AUTO_POLARITY_EN
                        // True polarity wins when both words qualify.
                        invert_d      = ~match_true_s;
`endif
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_DATA: begin
                    acc_d     = acc_shift_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_out_d   = acc_shift_s;
                        byte_valid_d = 1'b1;
                        byte_cnt_d   = byte_inc_s;
                        if (byte_inc_s == 8'(PAYLOAD_BYTES)) begin
                            // Clearing fill forces 16 fresh symbols before
                            // the next sync can be recognised.
                            frame_done_d = 1'b1;
                            state_d      = ST_HUNT;
                            fill_d       = 5'd0;
                            sr_d         = 16'd0;
`ifdef FSK_AUTO_POLARITY_EN
                            invert_d     = 1'b0;
`endif
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == ST_DATA);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            sr_q          <= 16'd0;
            fill_q        <= 5'd0;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= 8'd0;
            acc_q         <= 8'd0;
            bit_out_q     <= 1'b0;
            byte_out_q    <= 8'h00;
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            fill_q        <= fill_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            acc_q         <= acc_d;
            bit_out_q     <= bit_out_d;
            byte_out_q    <= byte_out_d;
            byte_valid_q  <= byte_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            locked_q      <= locked_d;
        end
    end

`ifdef FSK_AUTO_POLARITY_EN
    // Per-frame payload inversion flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            invert_q <= 1'b0;
        end else begin
            invert_q <= invert_d;
        end
    end
`endif

    assign bit_out     = bit_out_q;
    assign byte_out    = byte_out_q;
    assign byte_valid  = byte_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_fsk_frame_sync.sv
// ---------------------------------------------------------------------------
// tb_fsk_frame_sync
//
// Directed testbench for fsk_frame_sync: reset/idle, clean frame, sync error
// tolerance, slicer hysteresis, back-to-back strobes with a mid-frame reset,
// and the optional auto-polarity feature (FSK_AUTO_POLARITY_EN).
// ---------------------------------------------------------------------------
module tb_fsk_frame_sync;

    logic               clk;
    logic               reset;
    logic signed [15:0] x;
    logic               x_valid;
    logic               bit_out;
    logic [7:0]         byte_out;
    logic               byte_valid;
    logic               frame_start;
    logic               frame_done;
    logic               locked;

    int checks   = 0;
    int failures = 0;

    int fs_cnt   = 0;
    int fd_cnt   = 0;
    int bv_cnt   = 0;
    int fd_alone = 0;

    fsk_frame_sync dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .x_valid     (x_valid),
        .bit_out     (bit_out),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled on the inactive edge.
    always @(negedge clk) begin
        if (frame_start) fs_cnt++;
        if (byte_valid)  bv_cnt++;
        if (frame_done) begin
            fd_cnt++;
            if (!byte_valid) fd_alone++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One strobed sample after 'gap' idle cycles; returns at posedge+1 after
    // the strobe cycle, where that sample's registered effects are visible.
    task automatic send_x(input logic signed [15:0] v, input int gap);
        x_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        x       = v;
        x_valid = 1'b1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        send_x(b ? 16'sd4000 : -16'sd4000, gap);
    endtask

    task automatic send_word16(input logic [15:0] w, input int gap);
        for (int i = 15; i >= 0; i--) send_bit(w[i], gap);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
    endtask

    function automatic logic [31:0] outs_vec();
        return {20'd0, bit_out, byte_out, byte_valid, frame_start, frame_done, locked};
    endfunction

    int fs0, bv0, fd0;

    initial begin
        reset   = 1'b1;
        x       = 16'sd4000;
        x_valid = 1'b0;

        // Reset held with x_valid toggling.
        for (int i = 0; i < 4; i++) begin
            x_valid = ~x_valid;
            @(posedge clk);
            #1;
        end
        check("reset_outputs", outs_vec(), 32'd0);

        // Idle with x = 0.
        reset = 1'b0;
        x     = 16'sd0;
        for (int i = 0; i < 20; i++) begin
            x_valid = ~x_valid;
            @(posedge clk);
            #1;
        end
        x_valid = 1'b0;
        check("idle_bit_out", 32'(bit_out), 32'd0);
        check("idle_pulses", 32'(fs_cnt + bv_cnt + fd_cnt), 32'd0);

        // Clean frame, one strobe every 32 cycles.
        send_word16(16'hEB90, 31);
        check("clean_frame_start", 32'(frame_start), 32'd1);
        check("clean_locked_rise", 32'(locked), 32'd1);
        send_byte(8'h12, 31);
        check("clean_byte0", 32'(byte_out), 32'h12);
        send_byte(8'h34, 31);
        check("clean_byte1", 32'(byte_out), 32'h34);
        send_byte(8'h56, 31);
        check("clean_byte2", 32'(byte_out), 32'h56);
        send_byte(8'h78, 31);
        check("clean_byte3", 32'(byte_out), 32'h78);
        check("clean_last_valid", 32'(byte_valid), 32'd1);
        check("clean_frame_done", 32'(frame_done), 32'd1);
        check("clean_locked_fall", 32'(locked), 32'd0);
        @(posedge clk);
        #1;
        check("clean_fs_count", 32'(fs_cnt), 32'd1);
        check("clean_bv_count", 32'(bv_cnt), 32'd4);
        check("clean_fd_count", 32'(fd_cnt), 32'd1);
        check("clean_fd_alone", 32'(fd_alone), 32'd0);

        // One-bit-error sync is accepted.
        send_word16(16'hEB91, 0);
        check("err1_frame_start", 32'(frame_start), 32'd1);
        send_byte(8'hAA, 0);
        check("err1_byte0", 32'(byte_out), 32'hAA);
        send_byte(8'h55, 0);
        send_byte(8'h0F, 0);
        send_byte(8'hF0, 0);
        check("err1_byte3", 32'(byte_out), 32'hF0);
        check("err1_frame_done", 32'(frame_done), 32'd1);

        // Two-bit-error sync is rejected.
        fs0 = fs_cnt;
        @(posedge clk);
        #1;
        fs0 = fs_cnt;
        send_word16(16'hEB93, 0);
        check("err2_no_start", 32'(frame_start), 32'd0);
        for (int i = 0; i < 32; i++) send_bit(1'b0, 0);
        @(posedge clk);
        #1;
        check("err2_fs_count", 32'(fs_cnt), 32'(fs0));
        check("err2_unlocked", 32'(locked), 32'd0);

        // Slicer hysteresis boundaries.
        send_x(16'sd4000, 0);
        check("hyst_one", 32'(bit_out), 32'd1);
        send_x(16'sd256, 0);
        check("hyst_pos_edge_hold", 32'(bit_out), 32'd1);
        send_x(-16'sd256, 0);
        check("hyst_neg_edge_hold", 32'(bit_out), 32'd1);
        send_x(-16'sd257, 0);
        check("hyst_neg_cross", 32'(bit_out), 32'd0);
        send_x(16'sd257, 0);
        check("hyst_pos_cross", 32'(bit_out), 32'd1);
        send_x(16'sh8000, 0);
        check("hyst_min_value", 32'(bit_out), 32'd0);
        send_x(16'sd4000, 0);
        check("hyst_back_to_one", 32'(bit_out), 32'd1);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", outs_vec(), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Back-to-back strobes, reset after two payload bytes.
        @(posedge clk);
        #1;
        bv0 = bv_cnt;
        fd0 = fd_cnt;
        send_word16(16'hEB90, 0);
        check("b2b_frame_start", 32'(frame_start), 32'd1);
        send_byte(8'hC3, 0);
        check("b2b_byte0", 32'(byte_out), 32'hC3);
        send_byte(8'h3C, 0);
        check("b2b_byte1", 32'(byte_out), 32'h3C);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        reset = 1'b1;
        #1;
        check("b2b_reset_locked", 32'(locked), 32'd0);
        check("b2b_reset_byte_out", 32'(byte_out), 32'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("b2b_bv_count", 32'(bv_cnt), 32'(bv0 + 2));
        check("b2b_no_frame_done", 32'(fd_cnt), 32'(fd0));

        // Next sync after the aborted frame is accepted normally.
        send_word16(16'hEB90, 0);
        check("resync_frame_start", 32'(frame_start), 32'd1);
        send_byte(8'h01, 0);
        check("resync_byte0", 32'(byte_out), 32'h01);
        send_byte(8'h23, 0);
        send_byte(8'h45, 0);
        send_byte(8'h67, 0);
        check("resync_byte3", 32'(byte_out), 32'h67);
        check("resync_frame_done", 32'(frame_done), 32'd1);

        // Inverted sync word.
`ifdef FSK_AUTO_POLARITY_EN
        send_word16(16'h146F, 0);
        check("inv_frame_start", 32'(frame_start), 32'd1);
        send_byte(8'hED, 0);
        check("inv_byte0", 32'(byte_out), 32'h12);
        send_byte(8'hCB, 0);
        send_byte(8'hA9, 0);
        send_byte(8'h87, 0);
        check("inv_byte3", 32'(byte_out), 32'h78);
        check("inv_frame_done", 32'(frame_done), 32'd1);
`else
        send_word16(16'h146F, 0);
        check("inv_rejected", 32'(frame_start), 32'd0);
        check("inv_unlocked", 32'(locked), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
